regfile_write_arbiter: RTL and testbench

- Write-side front end for the CPU register file: merges two result sources onto the file's single write port (RegWrite / Write_register / Write_data).
- The in-order pipeline writeback takes priority; results from long-latency units (mult/div) arrive on a valid/ready handshake and wait in a small FIFO.
- Exports a pending-write mask so the hazard unit can stall readers of registers whose results are still queued.
- The register file captures the registered outputs of this block on the following negedge of clk.

---
 rtl/regfile_write_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and long-latency
// results wait in a small FIFO. Queued results that a newer pipeline write supersedes are killed.
module regfile_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_we,
    input  logic [4:0]       pipe_rd,
    input  logic [31:0]      pipe_data,
    input  logic             lu_valid,
    output logic             lu_ready,
    input  logic [4:0]       lu_rd,
    input  logic [31:0]      lu_data,
    output logic             RegWrite,
    output logic [4:0]       Write_register,
    output logic [31:0]      Write_data,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] live_q;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic        reg_write_q, reg_write_d;
    logic [4:0]  wr_reg_q, wr_reg_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic pipe_act, push, pop, push_live;

    // A pipeline write to r0 is treated exactly like an idle pipeline.
    assign pipe_act  = pipe_we && (pipe_rd != 5'd0);
    assign lu_ready  = (count_q < CNT_W'(DEPTH));
    assign push      = lu_valid && lu_ready;
    assign pop       = !pipe_act && (count_q != '0);
    assign push_live = (lu_rd != 5'd0) && !(pipe_we && (pipe_rd == lu_rd));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pipe_act) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_q[i] == pipe_rd) live_q[i] <= 1'b0;
                end
            end
            // Popped slots drop live so pending_mask only ever reflects occupied entries.
            if (pop) begin
                live_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                live_q[wr_ptr_q] <= push_live;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // NOTE: the payload storage is deliberately not reset; live_q and count_q qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= lu_rd;
            data_q[wr_ptr_q] <= lu_data;
        end
    end

    always_comb begin
        reg_write_d = 1'b0;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        if (pipe_act) begin
            reg_write_d = 1'b1;
            wr_reg_d    = pipe_rd;
            wr_data_d   = pipe_data;
        end else if (count_q != '0) begin
            reg_write_d = live_q[rd_ptr_q];
            wr_reg_d    = rd_q[rd_ptr_q];
            wr_data_d   = data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) pending_mask[rd_q[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    assign RegWrite       = reg_write_q;
    assign Write_register = wr_reg_q;
    assign Write_data     = wr_data_q;
    assign fifo_count     = count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued with their arrival
// cycle, and a negedge monitor matches every RegWrite pulse against the queue.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             pipe_we;
    logic [4:0]       pipe_rd;
    logic [31:0]      pipe_data;
    logic             lu_valid;
    logic             lu_ready;
    logic [4:0]       lu_rd;
    logic [31:0]      lu_data;
    logic             RegWrite;
    logic [4:0]       Write_register;
    logic [31:0]      Write_data;
    logic [31:0]      pending_mask;
    logic [CNT_W-1:0] fifo_count;

    regfile_write_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_we        (pipe_we),
        .pipe_rd        (pipe_rd),
        .pipe_data      (pipe_data),
        .lu_valid       (lu_valid),
        .lu_ready       (lu_ready),
        .lu_rd          (lu_rd),
        .lu_data        (lu_data),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .pending_mask   (pending_mask),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] rf_model [32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] data, input int at_cyc);
        exp_t e;
        e.rd = rd;
        e.data = data;
        e.cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    endtask

    // Monitor: register-file model plus in-order, cycle-exact matching of every write.
    always @(negedge clk) begin
        if (reset && RegWrite) begin
            rf_model[Write_register] = Write_data;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got rd %0d data %h, none expected (cycle %0d)",
                         Write_register, Write_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("write_rd", 32'(Write_register), 32'(e.rd));
                check("write_data", Write_data, e.data);
                check("write_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        idle_inputs();
        reset = 1'b0;
        #3;
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_wreg", 32'(Write_register), 32'd0);
        check("rst_wdata", Write_data, 32'd0);
        check("rst_pending", pending_mask, 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(lu_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();

        // 1: pipeline write, 1-cycle latency, then idle
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234;
        expect_write(5'd5, 32'h1234, cyc + 1);
        tick();
        idle_inputs();
        tick();
        check("t1_regwrite_off", 32'(RegWrite), 32'd0);

        // 2: single long-latency result, 2-cycle latency, pending bit for one cycle
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hAAAA;
        check("t2_ready", 32'(lu_ready), 32'd1);
        expect_write(5'd7, 32'hAAAA, cyc + 2);
        tick();
        idle_inputs();
        check("t2_pending", pending_mask, 32'h80);
        check("t2_count", 32'(fifo_count), 32'd1);
        tick();
        check("t2_pending_clear", pending_mask, 32'd0);
        check("t2_count_empty", 32'(fifo_count), 32'd0);
        tick();

        // 3: fill FIFO under continuous pipeline writes, full ignores lu_valid, then drain
        for (int i = 0; i < 4; i++) begin
            pipe_we = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h900 + 32'(i);
            lu_valid = 1'b1; lu_rd = 5'(i + 1); lu_data = 32'hB000 + 32'(i);
            expect_write(5'd9, 32'h900 + 32'(i), cyc + 1);
            tick();
        end
        check("t3_ready_full", 32'(lu_ready), 32'd0);
        check("t3_count_full", 32'(fifo_count), 32'd4);
        check("t3_pending", pending_mask, 32'h1E);
        pipe_data = 32'h904; lu_rd = 5'd30; lu_data = 32'hBAD0;
        expect_write(5'd9, 32'h904, cyc + 1);
        tick();
        check("t3_full_ignored", 32'(fifo_count), 32'd4);
        idle_inputs();
        c = cyc;
        for (int i = 0; i < 4; i++) expect_write(5'(i + 1), 32'hB000 + 32'(i), c + 1 + i);
        tick();
        check("t3_first_pop", 32'(fifo_count), 32'd3);
        repeat (4) tick();
        check("t3_drained", 32'(fifo_count), 32'd0);
        check("t3_pending_clear", pending_mask, 32'd0);

        // 4: queued rd=3 killed by a younger pipeline write to rd=3
        pipe_we = 1'b1; pipe_rd = 5'd10; pipe_data = 32'h0000_0A0A;
        lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'hA5A5_0003;
        expect_write(5'd10, 32'h0000_0A0A, cyc + 1);
        tick();
        lu_valid = 1'b0;
        check("t4_pending_set", pending_mask, 32'h8);
        pipe_rd = 5'd3; pipe_data = 32'hB0B0_0003;
        expect_write(5'd3, 32'hB0B0_0003, cyc + 1);
        tick();
        check("t4_pending_killed", pending_mask, 32'd0);
        check("t4_count_kept", 32'(fifo_count), 32'd1);
        idle_inputs();
        tick();
        check("t4_killed_pop_we", 32'(RegWrite), 32'd0);
        check("t4_killed_popped", 32'(fifo_count), 32'd0);
        tick();
        check("t4_reg3_final", rf_model[3], 32'hB0B0_0003);

        // 4b: same-cycle pipeline write and enqueue to the same register
        pipe_we = 1'b1; pipe_rd = 5'd12; pipe_data = 32'hC;
        lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'hD;
        expect_write(5'd12, 32'hC, cyc + 1);
        tick();
        idle_inputs();
        check("t4b_pending", pending_mask, 32'd0);
        check("t4b_count", 32'(fifo_count), 32'd1);
        tick();
        check("t4b_dead_pop_we", 32'(RegWrite), 32'd0);
        tick();
        check("t4b_reg12_final", rf_model[12], 32'hC);

        // 5: enqueue to r0 is accepted but never writes; pipe write to r0 is idle
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hDEAD;
        tick();
        idle_inputs();
        check("t5_count", 32'(fifo_count), 32'd1);
        check("t5_pending", pending_mask, 32'd0);
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFF;
        tick();
        idle_inputs();
        check("t5_pop_we", 32'(RegWrite), 32'd0);
        check("t5_popped", 32'(fifo_count), 32'd0);
        tick();

        // 6: three queued entries discarded by a mid-cycle reset
        for (int i = 0; i < 3; i++) begin
            pipe_we = 1'b1; pipe_rd = 5'd13; pipe_data = 32'hD00 + 32'(i);
            lu_valid = 1'b1; lu_rd = 5'(20 + i); lu_data = 32'hE00 + 32'(i);
            expect_write(5'd13, 32'hD00 + 32'(i), cyc + 1);
            tick();
        end
        idle_inputs();
        check("t6_count", 32'(fifo_count), 32'd3);
        check("t6_pending", pending_mask, 32'h0070_0000);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_regwrite", 32'(RegWrite), 32'd0);
        check("t6_rst_wreg", 32'(Write_register), 32'd0);
        check("t6_rst_wdata", Write_data, 32'd0);
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_pending", pending_mask, 32'd0);
        check("t6_rst_ready", 32'(lu_ready), 32'd1);
        tick();
        reset = 1'b1;
        repeat (4) tick();
        check("t6_no_write", 32'(RegWrite), 32'd0);
        check("t6_count_after", 32'(fifo_count), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
